minimac2_rx_writer: RTL and testbench
=====================================

Name: minimac2_rx_writer

Overview:
- PHY-side receive stage that feeds the minimac2 dual-port buffer memory through its byte-wide PHY port.
- Takes MII receive nibbles, strips the preamble and SFD, and assembles bytes low nibble first.
- Writes each byte at consecutive byte addresses from 0.
- Reports each completed frame's length and error status to the slot controller through a one-frame-per-arm handshake.

Parameters:
- ADDR_W, 11: byte address width into the buffer (2048-byte slot).
- MAX_BYTES, 2048: bytes written per frame before overflow; must be ≤ 2**ADDR_W.

Ports:
- phy_clk, input, 1: MII receive clock; the only clock.
- phy_rst, input, 1: asynchronous, active-high reset.
- phy_rx_dv, input, 1: MII receive data valid.
- phy_rx_er, input, 1: MII receive error.
- phy_rx_data, input, 4: MII receive nibble.
- rx_ready, input, 1: slot armed, already synchronised to phy_clk; each rising edge grants exactly one frame.
- phy_adr_o, output, ADDR_W: byte address to the buffer PHY port.
- phy_dat_o, output, 8: byte to write.
- phy_we_o, output, 1: single-cycle byte write strobe.
- rx_done, output, 1: one-cycle pulse when a frame completes.
- rx_count, output, ADDR_W+1: bytes written for the frame; valid with rx_done, held until the next rx_done.
- rx_err, output, 1: frame error flag; valid with rx_done, held until the next rx_done.
- rx_missed, output, 1: one-cycle pulse when a frame starts while not armed.

Behaviour:
Reset values:
- All outputs 0; state IDLE; armed=0.
- dv_prev=1, so a frame already in progress when reset releases is ignored until phy_rx_dv is seen low.
- Reset mid-frame aborts it: no rx_done, partial bytes left in memory.

Arming:
- rdy_prev is registered; armed is set on rx_ready 0→1.
- armed is cleared when IDLE accepts a frame start.
- rx_ready falling mid-frame has no effect.

FSM states:
- IDLE: on phy_rx_dv 0→1 (dv_prev=0):
  - armed=1 → PREAMBLE, clear armed.
  - armed=0 → DROP, pulse rx_missed.
- PREAMBLE:
  - nibble 0x5 → stay.
  - nibble 0xD → DATA; reset addr=0, count=0, phase=0, err=0.
  - any other nibble → DROP.
  - phy_rx_dv=0 → IDLE with no rx_done; armed is not restored.
- DATA:
  - phase 0: latch the low nibble.
  - phase 1: the next cycle drives phy_we_o=1, phy_dat_o={hi,lo}, phy_adr_o=addr; then addr++ and count++.
  - phy_rx_er=1 while phy_rx_dv=1 sets sticky err.
  - count==MAX_BYTES: further bytes are not written (phy_we_o stays 0), err set, stay in DATA.
  - phy_rx_dv=0: the next cycle pulses rx_done with rx_count=count and rx_err=err|(phase==1), where phase==1 means an odd dribble nibble (discarded); → IDLE.
  - A frame of zero data bytes still produces rx_done with count 0.
- DROP: phy_rx_dv=0 → IDLE; no outputs.

Latency and timing:
- Write strobe appears 1 cycle after the high nibble is sampled.
- rx_done appears 1 cycle after phy_rx_dv is first sampled low.
- phy_adr_o wraps never: count saturates at MAX_BYTES.
- A back-to-back frame (dv low for 1 cycle) is accepted only if rx_ready had a new rising edge.
- Simultaneous rx_ready rising edge and frame start in the same cycle: the arm is not yet visible, so the frame is DROPped and rx_missed pulses; armed is then set for the next frame.

Decomposition:
- minimac2_pkg holds:
  - the state enum {IDLE, PREAMBLE, DATA, DROP};
  - constants PREAMBLE_NIB=4'h5 and SFD_NIB=4'hD.
- One natural sub-module: minimac2_rx_nibble_asm (phase toggle, low-nibble latch, byte-valid strobe).
- The FSM, counters and handshake stay in the top level.

Test Plan:
- Normal frame:
  - Stimulus: rx_ready rise; 15×0x5, 0xD, then bytes 0x11,0x22,0x33 nibble-wise (1,1,2,2,3,3); dv low.
  - Response: three writes adr 0/1/2, dat 0x11/0x22/0x33; rx_done, rx_count=3, rx_err=0.
- Not armed:
  - Stimulus: frame with no rx_ready edge.
  - Response: rx_missed pulse, no writes, no rx_done; a following armed frame is received normally.
- Dribble and error:
  - Stimulus 1: 2 bytes plus 1 extra nibble.
  - Response 1: rx_count=2, rx_err=1.
  - Stimulus 2: a separate frame with phy_rx_er pulsed mid-data.
  - Response 2: all bytes written, rx_err=1.
- Overflow (MAX_BYTES=4):
  - Stimulus: 6-byte frame.
  - Response: writes only to adr 0..3; rx_count=4, rx_err=1.
- Bad SFD:
  - Stimulus: preamble then nibble 0x7.
  - Response: DROP, no writes, no rx_done; the next frame needs a new rx_ready edge.
- Reset mid-frame:
  - Stimulus: assert phy_rst during DATA, release with dv still high.
  - Response: outputs 0, rest of frame ignored, no rx_done; the next dv rising frame is accepted after arming.

Source files
------------

// File: rtl/minimac2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : minimac2_pkg                                                |
// | Purpose  : Shared types and constants for the minimac2 receive writer. |
// |            Holds the receive FSM state encoding and the MII preamble / |
// |            start-of-frame-delimiter nibble values.                     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package minimac2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  // MII transmits the low nibble first, so 0x55 preamble bytes arrive as a
  // run of 0x5 nibbles and the 0xD5 SFD ends with a 0xD nibble.
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

endpackage
`default_nettype wire

// File: rtl/minimac2_rx_nibble_asm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : minimac2_rx_nibble_asm                                      |
// | Purpose  : Pairs MII nibbles into bytes, low nibble first.             |
// | Ports    : clk, rst        - clock, asynchronous active-high reset     |
// |            clear_i         - restart at phase 0 (start of frame data)  |
// |            en_i            - nibble_i is a valid data nibble this cycle|
// |            nibble_i        - incoming nibble                           |
// |            phase_o         - 1 when a low nibble is held (odd count)   |
// |            byte_valid_o    - byte_o is complete this cycle             |
// |            byte_o          - {current nibble, latched low nibble}      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module minimac2_rx_nibble_asm (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [3:0] nibble_i,
  output logic       phase_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    if (clear_i) begin
      phase_d = 1'b0;
    end else if (en_i) begin
      if (!phase_q) begin
        lo_d = nibble_i;
      end
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      lo_q    <= 4'h0;
    end else begin
      phase_q <= phase_d;
      lo_q    <= lo_d;
    end
  end

  // The high nibble is not stored: the byte is handed on in the same cycle
  // it arrives, and the caller registers it.
  assign phase_o      = phase_q;
  assign byte_valid_o = en_i & phase_q & ~clear_i;
  assign byte_o       = {nibble_i, lo_q};

endmodule
`default_nettype wire

// File: rtl/minimac2_rx_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : minimac2_rx_writer                                          |
// | Purpose  : MII receive stage of minimac2. Strips preamble/SFD, builds  |
// |            bytes and writes them from address 0 into the buffer PHY    |
// |            port, then reports frame length and error status. One frame |
// |            is accepted per rising edge of rx_ready.                    |
// | Ports    : phy_clk, phy_rst            - clock, async active-high reset|
// |            phy_rx_dv/er/data           - MII receive interface         |
// |            rx_ready                    - arm (already in phy_clk)      |
// |            phy_adr_o/dat_o/we_o        - buffer byte write port        |
// |            rx_done, rx_count, rx_err   - frame completion report       |
// |            rx_missed                   - frame started while unarmed   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module minimac2_rx_writer
  import minimac2_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_BYTES = 2048
) (
  input  logic              phy_clk,
  input  logic              phy_rst,
  input  logic              phy_rx_dv,
  input  logic              phy_rx_er,
  input  logic [3:0]        phy_rx_data,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] phy_adr_o,
  output logic [7:0]        phy_dat_o,
  output logic              phy_we_o,
  output logic              rx_done,
  output logic [ADDR_W:0]   rx_count,
  output logic              rx_err,
  output logic              rx_missed
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_BYTES);

  rx_state_t         state_q, state_d;
  logic              dv_prev_q, rdy_prev_q;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] phy_adr_q, phy_adr_d;
  logic [7:0]        phy_dat_q, phy_dat_d;
  logic              phy_we_q, phy_we_d;
  logic              rx_done_q, rx_done_d;
  logic [ADDR_W:0]   rx_count_q, rx_count_d;
  logic              rx_err_q, rx_err_d;
  logic              rx_missed_q, rx_missed_d;

  logic       dv_rise, rdy_rise;
  logic       asm_clear, asm_en, asm_phase, asm_valid;
  logic [7:0] asm_byte;

  assign dv_rise  = phy_rx_dv & ~dv_prev_q;
  assign rdy_rise = rx_ready & ~rdy_prev_q;

  // Assembler controls decoded from registered state only, so the byte
  // strobe it returns does not loop back through the FSM logic.
  assign asm_clear = (state_q == PREAMBLE) & phy_rx_dv & (phy_rx_data == SFD_NIB);
  assign asm_en    = (state_q == DATA) & phy_rx_dv;

  minimac2_rx_nibble_asm u_nibble_asm (
    .clk          (phy_clk),
    .rst          (phy_rst),
    .clear_i      (asm_clear),
    .en_i         (asm_en),
    .nibble_i     (phy_rx_data),
    .phase_o      (asm_phase),
    .byte_valid_o (asm_valid),
    .byte_o       (asm_byte)
  );

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    phy_adr_d   = phy_adr_q;
    phy_dat_d   = phy_dat_q;
    phy_we_d    = 1'b0;
    rx_done_d   = 1'b0;
    rx_count_d  = rx_count_q;
    rx_err_d    = rx_err_q;
    rx_missed_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dv_rise) begin
          if (armed_q) begin
            state_d = PREAMBLE;
            armed_d = 1'b0;
          end else begin
            state_d     = DROP;
            rx_missed_d = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_d = IDLE;
        end else if (phy_rx_data == PREAMBLE_NIB) begin
          state_d = PREAMBLE;
        end else if (phy_rx_data == SFD_NIB) begin
          state_d = DATA;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (phy_rx_dv) begin
          if (phy_rx_er) begin
            err_d = 1'b1;
          end
          if (asm_valid) begin
            // Past the slot size the frame keeps being consumed but not
            // written, so the address never wraps over earlier data.
            if (count_q == MAX_CNT) begin
              err_d = 1'b1;
            end else begin
              phy_we_d  = 1'b1;
              phy_dat_d = asm_byte;
              phy_adr_d = addr_q;
              addr_d    = addr_q + ADDR_W'(1);
              count_d   = count_q + (ADDR_W + 1)'(1);
            end
          end
        end else begin
          // A held low nibble at end of frame is a dribble nibble.
          state_d    = IDLE;
          rx_done_d  = 1'b1;
          rx_count_d = count_q;
          rx_err_d   = err_q | asm_phase;
        end
      end

      DROP: begin
        if (!phy_rx_dv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Applied last: an edge arriving while IDLE consumes the previous grant
    // still leaves a grant for the following frame.
    if (rdy_rise) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge phy_clk or posedge phy_rst) begin
    if (phy_rst) begin
      state_q     <= IDLE;
      dv_prev_q   <= 1'b1;  // ignore a frame already in flight at reset
      rdy_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      phy_adr_q   <= '0;
      phy_dat_q   <= 8'h00;
      phy_we_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_count_q  <= '0;
      rx_err_q    <= 1'b0;
      rx_missed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dv_prev_q   <= phy_rx_dv;
      rdy_prev_q  <= rx_ready;
      armed_q     <= armed_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      phy_adr_q   <= phy_adr_d;
      phy_dat_q   <= phy_dat_d;
      phy_we_q    <= phy_we_d;
      rx_done_q   <= rx_done_d;
      rx_count_q  <= rx_count_d;
      rx_err_q    <= rx_err_d;
      rx_missed_q <= rx_missed_d;
    end
  end

  assign phy_adr_o = phy_adr_q;
  assign phy_dat_o = phy_dat_q;
  assign phy_we_o  = phy_we_q;
  assign rx_done   = rx_done_q;
  assign rx_count  = rx_count_q;
  assign rx_err    = rx_err_q;
  assign rx_missed = rx_missed_q;

endmodule
`default_nettype wire

// File: tb/tb_minimac2_rx_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_minimac2_rx_writer                                       |
// | Purpose  : Scoreboard bench for minimac2_rx_writer (MAX_BYTES = 4).    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_minimac2_rx_writer;

  localparam int ADDR_W    = 11;
  localparam int MAX_BYTES = 4;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_MISS = 2;

  logic              phy_clk = 1'b0;
  logic              phy_rst = 1'b1;
  logic              phy_rx_dv = 1'b0;
  logic              phy_rx_er = 1'b0;
  logic [3:0]        phy_rx_data = 4'h0;
  logic              rx_ready = 1'b0;
  logic [ADDR_W-1:0] phy_adr_o;
  logic [7:0]        phy_dat_o;
  logic              phy_we_o;
  logic              rx_done;
  logic [ADDR_W:0]   rx_count;
  logic              rx_err;
  logic              rx_missed;

  typedef struct {
    int kind;
    int a;
    int d;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 phy_clk = ~phy_clk;

  minimac2_rx_writer #(
    .ADDR_W    (ADDR_W),
    .MAX_BYTES (MAX_BYTES)
  ) dut (
    .phy_clk     (phy_clk),
    .phy_rst     (phy_rst),
    .phy_rx_dv   (phy_rx_dv),
    .phy_rx_er   (phy_rx_er),
    .phy_rx_data (phy_rx_data),
    .rx_ready    (rx_ready),
    .phy_adr_o   (phy_adr_o),
    .phy_dat_o   (phy_dat_o),
    .phy_we_o    (phy_we_o),
    .rx_done     (rx_done),
    .rx_count    (rx_count),
    .rx_err      (rx_err),
    .rx_missed   (rx_missed)
  );

  // ---------------- scoreboard ----------------
  function automatic void push(input int kind, input int a, input int d);
    exp_t e;
    e.kind = kind;
    e.a    = a;
    e.d    = d;
    sb.push_back(e);
  endfunction

  task automatic check_event(input string name, input int kind, input int a, input int d);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: unexpected event kind=%0d a=%0h d=%0h, required none", name, kind, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a != a || e.d != d) begin
        n_miss++;
        $display("FAIL %s: got kind=%0d a=%0h d=%0h, required kind=%0d a=%0h d=%0h",
                 name, kind, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge phy_clk) begin
    if (!phy_rst) begin
      if (phy_we_o)  check_event("write", K_WR, int'(phy_adr_o), int'(phy_dat_o));
      if (rx_done)   check_event("done", K_DONE, int'(rx_count), int'(rx_err));
      if (rx_missed) check_event("missed", K_MISS, 0, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmp(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_adr"},    int'(phy_adr_o), 0);
    cmp({tag, "_dat"},    int'(phy_dat_o), 0);
    cmp({tag, "_we"},     int'(phy_we_o), 0);
    cmp({tag, "_done"},   int'(rx_done), 0);
    cmp({tag, "_count"},  int'(rx_count), 0);
    cmp({tag, "_err"},    int'(rx_err), 0);
    cmp({tag, "_missed"}, int'(rx_missed), 0);
  endtask

  task automatic send(input logic dv, input logic er, input logic [3:0] d);
    @(posedge phy_clk);
    #1;
    phy_rx_dv   = dv;
    phy_rx_er   = er;
    phy_rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 4'h0);
  endtask

  task automatic arm();
    @(posedge phy_clk);
    #1 rx_ready = 1'b1;
    @(posedge phy_clk);
    #1 rx_ready = 1'b0;
  endtask

  // Byte k of 'bytes' sits at bits [8k+7:8k]; nibble i therefore at [4i+3:4i].
  task automatic frame(input logic [63:0] bytes, input int n, input bit dribble,
                       input int er_nib, input bit bad_sfd, input bit arm_at_start);
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 1'b0, 4'h5);
      if (arm_at_start && i == 0) rx_ready = 1'b1;
      if (i == 1) rx_ready = 1'b0;
    end
    send(1'b1, 1'b0, bad_sfd ? 4'h7 : 4'hD);
    for (int i = 0; i < 2 * n; i++) send(1'b1, (i == er_nib), bytes[i*4 +: 4]);
    if (dribble) send(1'b1, 1'b0, 4'hE);
    idle(4);
  endtask

  initial begin
    repeat (3) @(posedge phy_clk);
    #1 phy_rst = 1'b0;
    @(negedge phy_clk);
    check_zero("reset");

    // Normal frame: 0x11 0x22 0x33
    arm();
    push(K_WR, 0, 8'h11); push(K_WR, 1, 8'h22); push(K_WR, 2, 8'h33);
    push(K_DONE, 3, 0);
    frame(64'h332211, 3, 1'b0, -1, 1'b0, 1'b0);

    // Not armed: missed only, then an armed frame is received
    push(K_MISS, 0, 0);
    frame(64'h4444, 2, 1'b0, -1, 1'b0, 1'b0);
    arm();
    push(K_WR, 0, 8'hA5); push(K_WR, 1, 8'h5A); push(K_DONE, 2, 0);
    frame(64'h5AA5, 2, 1'b0, -1, 1'b0, 1'b0);

    // Dribble nibble: two bytes plus one odd nibble
    arm();
    push(K_WR, 0, 8'hC3); push(K_WR, 1, 8'h3C); push(K_DONE, 2, 1);
    frame(64'h3CC3, 2, 1'b1, -1, 1'b0, 1'b0);

    // rx_er pulsed on the third data nibble: all bytes still written
    arm();
    push(K_WR, 0, 8'h01); push(K_WR, 1, 8'h02); push(K_WR, 2, 8'h03);
    push(K_DONE, 3, 1);
    frame(64'h030201, 3, 1'b0, 2, 1'b0, 1'b0);

    // Overflow: six bytes, only four written
    arm();
    push(K_WR, 0, 8'h10); push(K_WR, 1, 8'h20); push(K_WR, 2, 8'h30);
    push(K_WR, 3, 8'h40); push(K_DONE, 4, 1);
    frame(64'h605040302010, 6, 1'b0, -1, 1'b0, 1'b0);

    // Zero data bytes
    arm();
    push(K_DONE, 0, 0);
    frame(64'h0, 0, 1'b0, -1, 1'b0, 1'b0);

    // Bad SFD consumes the grant; the next frame is missed
    arm();
    frame(64'h9999, 2, 1'b0, -1, 1'b1, 1'b0);
    push(K_MISS, 0, 0);
    frame(64'h8888, 2, 1'b0, -1, 1'b0, 1'b0);

    // rx_ready rises in the same cycle the frame starts: dropped, arm kept
    push(K_MISS, 0, 0);
    frame(64'h7777, 2, 1'b0, -1, 1'b0, 1'b1);
    push(K_WR, 0, 8'hBE); push(K_DONE, 1, 0);
    frame(64'hBE, 1, 1'b0, -1, 1'b0, 1'b0);

    // Reset mid-frame: one byte written, rest ignored, no done
    arm();
    push(K_WR, 0, 8'h11);
    for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 4'h5);
    send(1'b1, 1'b0, 4'hD);
    send(1'b1, 1'b0, 4'h1);
    send(1'b1, 1'b0, 4'h1);
    send(1'b1, 1'b0, 4'h2);
    @(posedge phy_clk);
    #1 phy_rst = 1'b1;
    @(negedge phy_clk);
    check_zero("in_reset");
    @(posedge phy_clk);
    #1 phy_rst = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 4'h3);
    idle(4);
    arm();
    push(K_WR, 0, 8'h77); push(K_DONE, 1, 0);
    frame(64'h77, 1, 1'b0, -1, 1'b0, 1'b0);

    idle(4);
    cmp("pending_expected", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
